// File: rtl/sa_col_collector.sv
// sa_col_collector
// Output stage of the weight-stationary systolic array. Captures skewed
// per-column partial sums into small deskew FIFOs. Once every column holds
// an entry, it pops one complete row vector. Each element is sign- or
// zero-extended and optionally accumulated into a per-row bank entry, then
// presented on a valid/ready port. sa_stall asks the array to freeze before
// any column FIFO can overflow.
//
// FIFO_DEPTH and ACC_DEPTH must be powers of two and at least 2, so that
// the pointers wrap naturally at their own width.
module sa_col_collector #(
  parameter int BIT_WIDTH  = 4,
  parameter int NUM_COL    = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           is_signed,
  input  logic [NUM_COL*3*BIT_WIDTH-1:0] psum_in,
  input  logic [NUM_COL-1:0]             psum_valid,
  input  logic                           acc_en,
  input  logic                           acc_clear,
  output logic [NUM_COL*ACC_WIDTH-1:0]   out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           sa_stall,
  output logic                           err_overflow
);

  localparam int PW  = 3 * BIT_WIDTH;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int VAW = $clog2(ACC_DEPTH);
  localparam logic [FAW:0] CNT_FULL = (FAW+1)'(FIFO_DEPTH);
  localparam logic [FAW:0] CNT_HIGH = (FAW+1)'(FIFO_DEPTH - 1);

  logic [PW-1:0]                fifo_mem   [NUM_COL][FIFO_DEPTH];
  logic [FAW-1:0]               wr_ptr     [NUM_COL];
  logic [FAW-1:0]               rd_ptr     [NUM_COL];
  logic [FAW:0]                 fifo_cnt   [NUM_COL];
  logic [NUM_COL-1:0]           fifo_full;
  logic [NUM_COL-1:0]           fifo_empty;
  logic [NUM_COL-1:0]           fifo_high;
  logic [NUM_COL-1:0]           push;
  logic                         pop;

  logic [PW-1:0]                fifo_head  [NUM_COL];
  logic [ACC_WIDTH-1:0]         col_ext    [NUM_COL];
  logic [NUM_COL*ACC_WIDTH-1:0] acc_result;

  logic [NUM_COL*ACC_WIDTH-1:0] bank       [ACC_DEPTH];
  logic [VAW-1:0]               vec_ptr;

  // FIFO status, push/pop qualification and stall request from registered counts
  always_comb begin
    fifo_full  = '0;
    fifo_empty = '0;
    fifo_high  = '0;
    push       = '0;
    for (int j = 0; j < NUM_COL; j++) begin
      fifo_full[j]  = (fifo_cnt[j] == CNT_FULL);
      fifo_empty[j] = (fifo_cnt[j] == '0);
      fifo_high[j]  = (fifo_cnt[j] >= CNT_HIGH);
      // A full FIFO drops the strobe even if it pops on the same edge.
      push[j]       = psum_valid[j] & ~fifo_full[j];
    end
    pop      = (fifo_empty == '0) && (!out_valid || out_ready);
    sa_stall = |fifo_high;
  end

  // Head extraction, extension and optional accumulation against the bank
  always_comb begin
    acc_result = '0;
    for (int j = 0; j < NUM_COL; j++) begin
      fifo_head[j] = fifo_mem[j][rd_ptr[j]];
      if (is_signed)
        col_ext[j] = ACC_WIDTH'($signed(fifo_head[j]));
      else
        col_ext[j] = ACC_WIDTH'(fifo_head[j]);
      if (acc_en && !acc_clear)
        acc_result[j*ACC_WIDTH +: ACC_WIDTH] =
          col_ext[j] + bank[vec_ptr][j*ACC_WIDTH +: ACC_WIDTH];
      else
        acc_result[j*ACC_WIDTH +: ACC_WIDTH] = col_ext[j];
    end
  end

  // Column FIFO storage; contents need no reset because the pointers are cleared
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_COL; j++) begin
      if (push[j])
        fifo_mem[j][wr_ptr[j]] <= psum_in[j*PW +: PW];
    end
  end

  // Column FIFO pointers and occupancy counts
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_COL; j++) begin
        wr_ptr[j]   <= '0;
        rd_ptr[j]   <= '0;
        fifo_cnt[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_COL; j++) begin
        if (push[j])
          wr_ptr[j] <= wr_ptr[j] + 1'b1;
        if (pop)
          rd_ptr[j] <= rd_ptr[j] + 1'b1;
        if (push[j] && !pop)
          fifo_cnt[j] <= fifo_cnt[j] + 1'b1;
        else if (!push[j] && pop)
          fifo_cnt[j] <= fifo_cnt[j] - 1'b1;
      end
    end
  end

  // Sticky overflow flag: any strobe that lands on a full column
  always_ff @(posedge clk) begin
    if (reset)
      err_overflow <= 1'b0;
    else if ((psum_valid & fifo_full) != '0)
      err_overflow <= 1'b1;
  end

  // Accumulator bank write-back and row pointer; the pointer advances on every pop
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_ptr <= '0;
      for (int i = 0; i < ACC_DEPTH; i++)
        bank[i] <= '0;
    end else if (pop) begin
      vec_ptr <= vec_ptr + 1'b1;
      if (acc_en)
        bank[vec_ptr] <= acc_result;
    end
  end

  // Output register: load on pop, drop valid on handshake, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= acc_result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sa_col_collector.sv
// Directed testbench for sa_col_collector with hand-computed expectations.
module tb_sa_col_collector;

  localparam int BW = 4;
  localparam int NC = 4;
  localparam int AW = 16;
  localparam int FD = 4;
  localparam int AD = 4;
  localparam int PW = 3 * BW;

  logic              clk = 1'b0;
  logic              reset;
  logic              is_signed;
  logic [NC*PW-1:0]  psum_in;
  logic [NC-1:0]     psum_valid;
  logic              acc_en;
  logic              acc_clear;
  logic [NC*AW-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              sa_stall;
  logic              err_overflow;

  int n_vec = 0;
  int n_err = 0;

  sa_col_collector #(
    .BIT_WIDTH (BW),
    .NUM_COL   (NC),
    .ACC_WIDTH (AW),
    .FIFO_DEPTH(FD),
    .ACC_DEPTH (AD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .is_signed   (is_signed),
    .psum_in     (psum_in),
    .psum_valid  (psum_valid),
    .acc_en      (acc_en),
    .acc_clear   (acc_clear),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sa_stall    (sa_stall),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {4{v}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset      = 1'b1;
    psum_valid = '0;
    tick;
    reset      = 1'b0;
  endtask

  // Strobe every column with the same value on one edge.
  task automatic push_all(input logic [11:0] v);
    psum_in    = {4{v}};
    psum_valid = '1;
    tick;
    psum_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    reset      = 1'b1;
    is_signed  = 1'b0;
    psum_in    = '0;
    psum_valid = '0;
    acc_en     = 1'b0;
    acc_clear  = 1'b0;
    out_ready  = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_stall", sa_stall, 0);
    check("rst_err", err_overflow, 0);

    // Basic deskew: columns strobed on consecutive edges
    for (int c = 0; c < NC; c++) begin
      psum_in = '0;
      psum_in[c*PW +: PW] = 12'(c + 1);
      psum_valid = 4'(1 << c);
      tick;
    end
    psum_valid = '0;
    check("deskew_not_early", out_valid, 0);
    tick;
    check("deskew_valid", out_valid, 1);
    check("deskew_data", out_data, 64'h0004_0003_0002_0001);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (out_valid) pulses++;
    end
    check("deskew_single_pulse", pulses, 0);

    // Sign / zero extension
    is_signed = 1'b1;
    push_all(12'hFFF);
    tick;
    check("sext_data", out_data, rep(16'hFFFF));
    is_signed = 1'b0;
    push_all(12'hFFF);
    tick;
    check("zext_data", out_data, rep(16'h0FFF));

    // Accumulation, unsigned
    do_reset;
    acc_en    = 1'b1;
    acc_clear = 1'b1;
    push_all(12'd5);
    tick;
    check("acc_first", out_data, rep(16'd5));
    for (int k = 0; k < 3; k++) begin
      push_all(12'(7 + 2 * k));
      tick;
    end
    acc_clear = 1'b0;
    push_all(12'd3);
    tick;
    check("acc_wrap_sum", out_data, rep(16'd8));

    // Accumulation, signed, then modulo wrap of the bank entry
    do_reset;
    is_signed = 1'b1;
    acc_clear = 1'b1;
    push_all(12'hFFE);
    tick;
    check("acc_signed_first", out_data, rep(16'hFFFE));
    for (int k = 0; k < 3; k++) begin
      push_all(12'd0);
      tick;
    end
    acc_clear = 1'b0;
    push_all(12'd1);
    tick;
    check("acc_signed_sum", out_data, rep(16'hFFFF));
    acc_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push_all(12'd0);
      tick;
    end
    acc_en = 1'b1;
    push_all(12'd2);
    tick;
    check("acc_modulo", out_data, rep(16'h0001));
    acc_en    = 1'b0;
    is_signed = 1'b0;

    // Backpressure
    do_reset;
    out_ready = 1'b0;
    push_all(12'h011);
    push_all(12'h022);
    check("bp_v1_valid", out_valid, 1);
    check("bp_v1_data", out_data, rep(16'h0011));
    push_all(12'h033);
    check("bp_stall_two", sa_stall, 0);
    push_all(12'h044);
    check("bp_stall_three", sa_stall, 1);
    check("bp_hold_a", out_data, rep(16'h0011));
    tick;
    check("bp_hold_b", out_data, rep(16'h0011));
    check("bp_hold_valid", out_valid, 1);
    check("bp_stall_hold", sa_stall, 1);
    out_ready = 1'b1;
    tick;
    check("bp_v2", out_data, rep(16'h0022));
    check("bp_stall_drop", sa_stall, 0);
    tick;
    check("bp_v3", out_data, rep(16'h0033));
    tick;
    check("bp_v4", out_data, rep(16'h0044));
    check("bp_v4_valid", out_valid, 1);
    tick;
    check("bp_drain", out_valid, 0);

    // Overflow on column 0
    do_reset;
    for (int k = 1; k <= 5; k++) begin
      psum_in = '0;
      psum_in[11:0] = 12'(k);
      psum_valid = 4'b0001;
      tick;
      if (k == 3) check("ovf_stall", sa_stall, 1);
      if (k == 4) check("ovf_err_clear", err_overflow, 0);
      if (k == 5) check("ovf_err_set", err_overflow, 1);
    end
    psum_valid = '0;
    tick;
    tick;
    check("ovf_err_sticky", err_overflow, 1);
    for (int k = 0; k < 4; k++) begin
      psum_in = {{3{12'(12'h100 + k)}}, 12'h000};
      psum_valid = 4'b1110;
      tick;
      if (k >= 1)
        check("ovf_order", out_data,
              {{3{16'(16'h100 + k - 1)}}, 16'(k)});
    end
    psum_valid = '0;
    tick;
    check("ovf_order_last", out_data, {{3{16'h0103}}, 16'h0004});
    check("ovf_err_end", err_overflow, 1);

    // Reset mid-operation
    do_reset;
    out_ready = 1'b0;
    push_all(12'h0AA);
    tick;
    check("mid_valid_pre", out_valid, 1);
    psum_in    = {4{12'h0BB}};
    psum_valid = 4'b0011;
    tick;
    reset      = 1'b1;
    psum_in    = {4{12'h0CC}};
    psum_valid = 4'b0100;
    tick;
    reset      = 1'b0;
    psum_valid = '0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_stall", sa_stall, 0);
    check("mid_rst_err", err_overflow, 0);
    out_ready = 1'b1;
    acc_en    = 1'b1;
    acc_clear = 1'b1;
    push_all(12'd7);
    tick;
    check("mid_fresh_data", out_data, rep(16'd7));
    tick;
    check("mid_single", out_valid, 0);
    acc_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push_all(12'd0);
      tick;
    end
    acc_en    = 1'b1;
    acc_clear = 1'b0;
    push_all(12'd1);
    tick;
    check("mid_ptr_zero", out_data, rep(16'd8));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
